bootrom_loader: RTL and testbench

- Writer-side front end for the boot-ROM dual-port RAM's 16-bit port B.
- Consumes the HPS/ioctl byte-download stream (8-bit, byte-addressed) and packs byte pairs little-endian into 16-bit words.
- Issues single-cycle word writes on address_b/data_b/wren_b, so the 8-bit CPU-side port A sees the ROM image byte-for-byte.
- Sits between the download controller and the RAM instance in the GameBoy top level.

---
 rtl/bootrom_loader_pkg.sv | 22 ++
 rtl/bootrom_loader_edge_detect.sv | 24 ++
 rtl/bootrom_loader.sv | 153 +++++++++++++++
 tb/tb_bootrom_loader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bootrom_loader_pkg.sv
// Shared types and helpers for the boot-ROM download loader and its siblings.
// Holds the loader state encoding, the ioctl address width and the capacity helper.
package bootrom_loader_pkg;

  localparam int IOCTL_ADDR_W = 25;

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    FLUSH,
    DONE
  } state_t;

  // Byte capacity of a 16-bit RAM port with aw word-address bits.
  function automatic logic [IOCTL_ADDR_W-1:0] capacity_bytes(input int aw);
    logic [IOCTL_ADDR_W-1:0] one;
    one = {{(IOCTL_ADDR_W-1){1'b0}}, 1'b1};
    return one << (aw + 1);
  endfunction

endpackage

// File: rtl/bootrom_loader_edge_detect.sv
// Registers a level and produces single-cycle rise/fall pulses against the registered copy.
// Shared by the ioctl download consumers to detect transfer start and end.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_q;
  assign o_fall = ~i_level & r_level_q;

endmodule

// File: rtl/bootrom_loader.sv
// Packs the ioctl byte-download stream little-endian into 16-bit word writes for boot-ROM port B.
// Tracks sequential offsets, flags gaps/overflow, and pads a trailing odd byte on transfer end.
module bootrom_loader
  import bootrom_loader_pkg::*;
#(
  parameter int                      ADDR_WIDTH_B = 11,
  parameter logic [IOCTL_ADDR_W-1:0] BASE_ADDR    = 25'h0,
  parameter logic [7:0]              PAD_BYTE     = 8'h00
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic [ADDR_WIDTH_B-1:0] address_b,
  output logic [15:0]             data_b,
  output logic                    wren_b,
  output logic [ADDR_WIDTH_B:0]   word_count,
  output logic                    done,
  output logic                    error
);

  localparam logic [IOCTL_ADDR_W-1:0] CAPACITY  = capacity_bytes(ADDR_WIDTH_B);
  localparam logic [ADDR_WIDTH_B:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH_B{1'b0}}};

  state_t                  r_state;
  logic [IOCTL_ADDR_W-1:0] r_exp;
  logic [7:0]              r_low;
  logic [ADDR_WIDTH_B-1:0] r_low_word;
  logic [ADDR_WIDTH_B-1:0] r_address;
  logic [15:0]             r_data;
  logic                    r_wren;
  logic [ADDR_WIDTH_B:0]   r_count;
  logic                    r_done;
  logic                    r_error;

  logic                    w_rise;
  logic                    w_fall;
  logic                    w_accept;
  logic [IOCTL_ADDR_W-1:0] w_off;
  logic                    w_in_range;
  logic                    w_take;
  logic                    w_take_first;
  logic                    w_bad;

  function automatic logic [ADDR_WIDTH_B:0] sat_inc(input logic [ADDR_WIDTH_B:0] cnt);
    return (cnt == COUNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  edge_detect u_edge (
    .clock   (clock),
    .reset   (reset),
    .i_level (ioctl_download),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_accept   = ioctl_wr & ioctl_download;
  assign w_off      = ioctl_addr - BASE_ADDR;
  assign w_in_range = (w_off < CAPACITY);
  assign w_take     = w_accept & w_in_range & (w_off == r_exp);
  assign w_bad      = w_accept & ~(w_in_range & (w_off == r_exp));
  // On the rise cycle the expected offset is being cleared, so the first byte must be offset 0.
  assign w_take_first = w_accept & w_in_range & (w_off == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_exp      <= '0;
      r_low      <= '0;
      r_low_word <= '0;
      r_address  <= '0;
      r_data     <= '0;
      r_wren     <= 1'b0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      if (w_rise) begin
        r_done  <= 1'b0;
        r_count <= '0;
        if (w_take_first) begin
          r_low      <= ioctl_dout;
          r_low_word <= w_off[ADDR_WIDTH_B:1];
          r_exp      <= {{(IOCTL_ADDR_W-1){1'b0}}, 1'b1};
          r_error    <= 1'b0;
          r_state    <= HIGH;
        end else begin
          r_exp   <= '0;
          r_error <= w_accept;
          r_state <= LOW;
        end
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          LOW: begin
            if (w_fall) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_take) begin
              r_low      <= ioctl_dout;
              r_low_word <= w_off[ADDR_WIDTH_B:1];
              r_exp      <= r_exp + 1'b1;
              r_state    <= HIGH;
            end else if (w_bad) begin
              r_error <= 1'b1;
            end
          end
          HIGH: begin
            if (w_fall) begin
              r_wren    <= 1'b1;
              r_data    <= {PAD_BYTE, r_low};
              r_address <= r_low_word;
              r_count   <= sat_inc(r_count);
              r_state   <= FLUSH;
            end else if (w_take) begin
              r_wren    <= 1'b1;
              r_data    <= {ioctl_dout, r_low};
              r_address <= w_off[ADDR_WIDTH_B:1];
              r_count   <= sat_inc(r_count);
              r_exp     <= r_exp + 1'b1;
              r_state   <= LOW;
            end else if (w_bad) begin
              r_error <= 1'b1;
            end
          end
          FLUSH: begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end
          DONE: begin
            r_state <= DONE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign address_b  = r_address;
  assign data_b     = r_data;
  assign wren_b     = r_wren;
  assign word_count = r_count;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_bootrom_loader.sv
// Bench for bootrom_loader: a full-size and a tiny (4-word) instance share one ioctl stream,
// each compared cycle by cycle against a byte-list reference model.
module tb_bootrom_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic [10:0] addr0;
  logic [15:0] data0;
  logic        wren0;
  logic [11:0] cnt0;
  logic        done0, err0;

  logic [1:0]  addr1;
  logic [15:0] data1;
  logic        wren1;
  logic [2:0]  cnt1;
  logic        done1, err1;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state, index 0 = full instance, 1 = 4-word instance
  int  cap[2];
  int  m_exp[2], m_low[2], m_count[2];
  bit  m_err[2], m_done[2], m_done_next[2], m_active[2];
  bit  e_v[2];
  int  e_d[2], e_a[2];
  bit  e_zero_dp;
  bit  dl_prev;

  always #5 clk = ~clk;

  bootrom_loader #(.ADDR_WIDTH_B(11)) u_dut (
    .clock(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .address_b(addr0), .data_b(data0),
    .wren_b(wren0), .word_count(cnt0), .done(done0), .error(err0));

  bootrom_loader #(.ADDR_WIDTH_B(2)) u_dut_small (
    .clock(clk), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .address_b(addr1), .data_b(data1),
    .wren_b(wren1), .word_count(cnt1), .done(done1), .error(err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] o_w, o_a, o_d, o_c, o_dn, o_e;
      if (i == 0) begin
        o_w = 32'(wren0); o_a = 32'(addr0); o_d = 32'(data0);
        o_c = 32'(cnt0);  o_dn = 32'(done0); o_e = 32'(err0);
      end else begin
        o_w = 32'(wren1); o_a = 32'(addr1); o_d = 32'(data1);
        o_c = 32'(cnt1);  o_dn = 32'(done1); o_e = 32'(err1);
      end
      check($sformatf("wren_b[%0d]", i), o_w, 32'(e_v[i]));
      if (e_v[i] || e_zero_dp) begin
        check($sformatf("address_b[%0d]", i), o_a, 32'(e_a[i]));
        check($sformatf("data_b[%0d]", i), o_d, 32'(e_d[i]));
      end
      check($sformatf("word_count[%0d]", i), o_c, 32'(m_count[i]));
      check($sformatf("done[%0d]", i), o_dn, 32'(m_done[i]));
      check($sformatf("error[%0d]", i), o_e, 32'(m_err[i]));
    end
  endtask

  // One clock of stimulus: drive download level and optional byte strobe, advance model, compare.
  task automatic step(input bit dl, input bit wr, input int addr, input int data);
    bit rise, fall;
    rise = dl && !dl_prev;
    fall = !dl && dl_prev;
    ioctl_download = dl;
    ioctl_wr       = wr;
    ioctl_addr     = addr[24:0];
    ioctl_dout     = data[7:0];
    e_zero_dp      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e_v[i] = 1'b0;
      if (m_done_next[i]) begin
        m_done[i]      = 1'b1;
        m_done_next[i] = 1'b0;
      end
      if (rise) begin
        m_exp[i] = 0; m_count[i] = 0; m_err[i] = 0; m_done[i] = 0;
        m_active[i] = 1'b1;
      end
      if (fall && m_active[i]) begin
        m_active[i] = 1'b0;
        if (m_exp[i] % 2 == 1) begin
          e_v[i] = 1'b1;
          e_d[i] = m_low[i] & 8'hFF;
          e_a[i] = m_exp[i] / 2;
          m_count[i]++;
          m_done_next[i] = 1'b1;
        end else begin
          m_done[i] = 1'b1;
        end
      end else if (wr && dl && m_active[i]) begin
        if (addr == m_exp[i] && addr < cap[i]) begin
          if (m_exp[i] % 2 == 1) begin
            e_v[i] = 1'b1;
            e_d[i] = ((data & 8'hFF) << 8) | (m_low[i] & 8'hFF);
            e_a[i] = m_exp[i] / 2;
            m_count[i]++;
          end else begin
            m_low[i] = data;
          end
          m_exp[i]++;
        end else begin
          m_err[i] = 1'b1;
        end
      end
    end
    dl_prev = dl;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic send_bytes(input int first, input int n, input int base_data);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, first + k, base_data + k * 37);
  endtask

  task automatic end_xfer();
    step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_exp[i] = 0; m_low[i] = 0; m_count[i] = 0; m_err[i] = 0;
      m_done[i] = 0; m_done_next[i] = 0; m_active[i] = 0;
      e_v[i] = 0; e_d[i] = 0; e_a[i] = 0;
    end
    dl_prev = 1'b0;
  endtask

  task automatic apply_reset();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    reset          = 1'b1;
    #1;
    model_clear();
    e_zero_dp = 1'b1;
    compare_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    int len, gap;
    cap[0] = 4096;
    cap[1] = 8;
    ioctl_addr = '0;
    ioctl_dout = '0;
    apply_reset();

    // even image
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8'h31);
    step(1'b1, 1'b1, 1, 8'h00);
    step(1'b1, 1'b1, 2, 8'hFE);
    step(1'b1, 1'b1, 3, 8'hFF);
    check("even_last_data", 32'(data0), 32'h0000FFFE);
    end_xfer();
    check("even_count", 32'(cnt0), 32'd2);

    // odd image with padded flush
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8'hAA);
    step(1'b1, 1'b1, 1, 8'hBB);
    step(1'b1, 1'b1, 2, 8'hCC);
    step(1'b0, 1'b0, 0, 0);
    check("odd_flush_data", 32'(data0), 32'h000000CC);
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8'h11);  // the new rise with an immediate first byte

    // back-to-back 256 bytes, restarted cleanly
    end_xfer();
    step(1'b1, 1'b0, 0, 0);
    for (int k = 0; k < 256; k++) step(1'b1, 1'b1, k, $urandom_range(0, 255));
    end_xfer();
    check("b2b_count", 32'(cnt0), 32'd128);

    // non-sequential
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8'h01);
    step(1'b1, 1'b1, 1, 8'h02);
    step(1'b1, 1'b1, 5, 8'h03);
    end_xfer();

    // overflow on the 4-word instance
    step(1'b1, 1'b0, 0, 0);
    send_bytes(0, 10, 8'h40);
    end_xfer();
    check("ovf_count_small", 32'(cnt1), 32'd4);
    check("ovf_err_small", 32'(err1), 32'd1);

    // reset while holding a low byte
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8'h12);
    apply_reset();
    step(1'b0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 0, 8'h34);
    step(1'b1, 1'b1, 1, 8'h56);
    check("post_reset_word", 32'(data0), 32'h00005634);
    end_xfer();

    // randomized transfers with gaps, stray addresses and strobes on the rise cycle
    for (int t = 0; t < 30; t++) begin
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 3) != 0) step(1'b1, 1'b0, 0, 0);
      for (int k = 0; k < len; k++) begin
        gap = $urandom_range(0, 4);
        if (gap == 0 && dl_prev) step(1'b1, 1'b0, 0, 0);
        if ($urandom_range(0, 9) == 0) step(1'b1, 1'b1, $urandom_range(0, 40), $urandom_range(0, 255));
        else step(1'b1, 1'b1, m_exp[0], $urandom_range(0, 255));
      end
      end_xfer();
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b1, 0, 8'h77);  // strobe without download
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
